// File: rtl/gaussian_cdt_sampler.sv
// gaussian_cdt_sampler
//   Pulls one 64-bit uniform word from the Tausworthe generator and maps it to a
//   signed discrete-Gaussian sample. The magnitude comes from a binary search over
//   a programmable cumulative distribution table (CDT). The sign comes from bit 63.
//   Negative zero is rejected and redrawn, so zero is not sampled twice as often
//   as any other value.
//
// Ports
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   en               start new draws only while high (checked in IDLE)
//   rng_ce           one-cycle request pulse to the uniform generator
//   rng_valid/data   generator response, one cycle after rng_ce
//   tab_we/addr/data CDT write port, honoured only while not busy
//   smp_valid/ready  valid/ready handshake toward the polynomial/NTT consumers
//   smp_data         signed two's-complement sample
//   busy             high in any state other than IDLE
//   rej_cnt          saturating count of rejected negative-zero draws
module gaussian_cdt_sampler #(
  parameter int LOG2_DEPTH = 4,
  parameter int OUT_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  output logic                  rng_ce,
  input  logic                  rng_valid,
  input  logic [63:0]           rng_data,
  input  logic                  tab_we,
  input  logic [LOG2_DEPTH-1:0] tab_addr,
  input  logic [62:0]           tab_data,
  output logic                  smp_valid,
  input  logic                  smp_ready,
  output logic [OUT_W-1:0]      smp_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      rej_cnt
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] IDX_ONE   = LOG2_DEPTH'(1);
  // Search step as a one-hot weight 2^b, starting at the MSB of the index.
  localparam logic [LOG2_DEPTH-1:0] STEP_INIT = IDX_ONE << (LOG2_DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEARCH,
    S_OUT
  } state_e;

  state_e                    state_q, state_d;
  logic [DEPTH-1:0][62:0]    cdt_q;
  logic                      sign_q, sign_d;
  logic [62:0]               u_q, u_d;
  logic [LOG2_DEPTH-1:0]     idx_q, idx_d;
  logic [LOG2_DEPTH-1:0]     step_q, step_d;
  logic [OUT_W-1:0]          smp_q, smp_d;
  logic [CNT_W-1:0]          rej_q, rej_d;

  // One binary-search probe per cycle. The probe never reaches DEPTH-1, so the
  // last table entry is stored but never compared.
  logic [LOG2_DEPTH-1:0]     probe;
  logic                      hit;
  logic [LOG2_DEPTH-1:0]     idx_next;
  logic [OUT_W-1:0]          mag;

  assign probe    = idx_q + step_q - IDX_ONE;
  assign hit      = (cdt_q[probe] <= u_q);
  assign idx_next = hit ? (idx_q + step_q) : idx_q;
  assign mag      = OUT_W'(idx_next);

  assign rng_ce    = (state_q == S_REQ);
  assign smp_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign smp_data  = smp_q;
  assign rej_cnt   = rej_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    u_d     = u_q;
    idx_d   = idx_q;
    step_d  = step_q;
    smp_d   = smp_q;
    rej_d   = rej_q;
    case (state_q)
      S_IDLE: begin
        if (en && !smp_valid) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rng_valid) begin
          sign_d  = rng_data[63];
          u_d     = rng_data[62:0];
          idx_d   = '0;
          step_d  = STEP_INIT;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        idx_d  = idx_next;
        step_d = step_q >> 1;
        if (step_q[0]) begin
          if (sign_q && (idx_next == '0)) begin
            // Negative zero: redraw without rechecking en.
            if (rej_q != '1) rej_d = rej_q + CNT_ONE;
            state_d = S_REQ;
          end else begin
            smp_d   = sign_q ? (-mag) : mag;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (smp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      u_q     <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      smp_q   <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      u_q     <= u_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      smp_q   <= smp_d;
      rej_q   <= rej_d;
    end
  end

  // The table is only writable in IDLE so that a search never sees an entry
  // change between probes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cdt_q <= '0;
    end else if (tab_we && (state_q == S_IDLE)) begin
      cdt_q[tab_addr] <= tab_data;
    end
  end

endmodule

// File: doc/gaussian_cdt_sampler.md
Name: gaussian_cdt_sampler

Overview:
- Downstream stage of the 64-bit Tausworthe uniform generator.
- Requests one uniform word at a time by pulsing the generator's clock enable, then maps it to a signed discrete-Gaussian sample.
- Mapping is a sequential binary search over a programmable cumulative distribution table (CDT) plus a sign bit.
- Delivers samples to the polynomial/NTT consumers over a valid/ready interface.

Parameters:
- LOG2_DEPTH, 4, log2 of CDT entry count; DEPTH = 2^LOG2_DEPTH.
- OUT_W, 8, signed sample width; DEPTH-1 must be below 2^(OUT_W-1).
- CNT_W, 16, width of the rejection counter.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous reset, active low
- en  in  1  sampler enable; start new draws only while high
- rng_ce  out  1  clock enable to the uniform generator, one-cycle pulse per request
- rng_valid  in  1  generator output valid; arrives one cycle after rng_ce
- rng_data  in  64  generator uniform word
- tab_we  in  1  CDT write strobe
- tab_addr  in  LOG2_DEPTH  CDT write index
- tab_data  in  63  CDT threshold value
- smp_valid  out  1  sample valid
- smp_ready  in  1  downstream accept
- smp_data  out  OUT_W  signed two's-complement sample
- busy  out  1  high in any state other than IDLE
- rej_cnt  out  CNT_W  count of rejected negative-zero draws, saturating

Behaviour:
- Reset (async, rstn=0):
  - State goes to IDLE.
  - rng_ce, smp_valid, busy = 0; smp_data = 0; rej_cnt = 0.
  - All CDT entries = 0; captured word and search index = 0.
  - Any draw in flight is discarded; a rng_valid arriving after reset release while in IDLE is ignored.
- CDT:
  - DEPTH registers of 63 bits, written on tab_we when busy=0.
  - tab_we while busy=1 is ignored; the table is unchanged.
  - The table is assumed ascending. Entry DEPTH-1 is never compared.
- Word split: sign = rng_data[63]; u = rng_data[62:0], unsigned.
- Magnitude: k = number of entries i in 0..DEPTH-2 with CDT[i] <= u, i.e. the smallest i with u < CDT[i], saturating at DEPTH-1.
- Binary search:
  - idx starts at 0.
  - For b = LOG2_DEPTH-1 down to 0, one step per cycle: if CDT[idx + 2^b - 1] <= u, then idx += 2^b.
  - Final idx = k.
- FSM:
  - IDLE: if en=1 and smp_valid=0 -> REQ.
  - REQ: rng_ce=1 for exactly this cycle -> WAIT.
  - WAIT: hold until rng_valid=1; latch rng_data; clear idx -> SEARCH. rng_valid outside WAIT is ignored.
  - SEARCH: LOG2_DEPTH cycles, one comparison each. At the end:
    - If sign=1 and k=0 (negative zero): reject, rej_cnt += 1 saturating at all-ones, -> REQ. en is not rechecked.
    - Otherwise: smp_data = sign ? -k : k; smp_valid=1 -> OUT.
  - OUT: hold smp_valid and smp_data stable until smp_ready=1. On accept: smp_valid=0 next cycle -> IDLE.
- Latency: with rng_ce asserted in cycle t and rng_valid in t+1, smp_valid rises at t+2+LOG2_DEPTH (t+6 at defaults).
- Throughput: one sample per LOG2_DEPTH+3 cycles minimum; IDLE costs one cycle after each accept.
- Enable:
  - en falling mid-draw does not abort; the current sample completes and is held.
  - en is sampled only in IDLE.
- smp_ready while smp_valid=0 has no effect.

Test Plan:
- Reset with table all zero; en=1; rng_data=0x0000_0000_0000_0000 -> k saturates to 15, smp_data=8'h0F. rng_ce pulses one cycle at t, smp_valid at t+6.
- Program CDT[i]=(i+1)·2^59 for i=0..14; rng_data=0x1800_0000_0000_0000 -> smp_data=+3 (8'h03). rng_data=0x9800_0000_0000_0000 -> smp_data=-3 (8'hFD).
- Same table; rng_data=0x8000_0000_0000_0001 then 0x0000_0000_0000_0000 -> first word rejected, rej_cnt=1, second rng_ce pulse issued, smp_data=0. rng_data=0x7FFF_FFFF_FFFF_FFFF -> smp_data=8'h0F.
- smp_ready held low 10 cycles after smp_valid -> smp_data stable, no rng_ce pulses, busy=1. Raise smp_ready -> smp_valid=0 next cycle, new rng_ce two cycles after accept when en=1.
- tab_we to address 2 with value 0 during SEARCH -> table unchanged, result matches the pre-write table. Same write in IDLE takes effect on the next draw.
- rstn asserted mid-SEARCH -> outputs 0 immediately (asynchronous). After release with en=0: no rng_ce, and a stray rng_valid is ignored.
